// File: rtl/spi_reg_master.sv
// -----------------------------------------------------------------------------
// spi_reg_master
// Single-channel-at-a-time SPI register master (mode 0: SCLK idles low, MISO is
// sampled on the SCLK rise, MOSI changes on the SCLK fall).
//
// Frame layout (N = 1 + A + D bits): R/W bit (1 = write), address, data.
// For reads the data bits on MOSI are zero. The D bits received during the
// data field are presented on DATAO in the DONE cycle.
//
// Build option:
//   SPI_REG_MASTER_LSB_FIRST_EN  defined   -> address and data fields (MOSI and
//                                             MISO) are shifted LSB first
//                                undefined -> MSB first (default)
//   The R/W bit is always the first bit of the frame.
//
// Parameters:
//   D    data bits per frame
//   A    address bits per frame
//   DIV  CLOCK cycles per SCLK half-period (>= 1)
//   NSS  slave-select channels (1..8)
//
// Ports:
//   CLOCK  in   system clock
//   RESET  in   asynchronous active-high reset
//   DATAI  in   [D]  write data
//   ADDR   in   [A]  register address
//   SEL    in   [SW] slave channel, SW = max(1, clog2(NSS))
//   WR     in   write strobe (wins over RD)
//   RD     in   read strobe
//   DATAO  out  [D]  last read data
//   BUSY   out  transfer active
//   DONE   out  one-cycle completion pulse
//   SS     out  [NSS] active-low slave selects
//   SCLK   out  serial clock
//   MOSI   out  serial data out
//   MISO   in   serial data in
// -----------------------------------------------------------------------------
module spi_reg_master #(
  parameter int D   = 8,
  parameter int A   = 8,
  parameter int DIV = 2,
  parameter int NSS = 1
) (
  input  logic                                      CLOCK,
  input  logic                                      RESET,
  input  logic [D-1:0]                              DATAI,
  input  logic [A-1:0]                              ADDR,
  input  logic [((NSS > 1) ? $clog2(NSS) : 1)-1:0]  SEL,
  input  logic                                      WR,
  input  logic                                      RD,
  output logic [D-1:0]                              DATAO,
  output logic                                      BUSY,
  output logic                                      DONE,
  output logic [NSS-1:0]                            SS,
  output logic                                      SCLK,
  output logic                                      MOSI,
  input  logic                                      MISO
);

  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1;
  localparam int N  = 1 + A + D;
  // Divider counts 0..DIV-1 inside each phase; bit counter counts 0..N-1.
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [NW-1:0]   bit_q;
  logic [N-1:0]    tx_q;
  logic [D-1:0]    rx_q;
  logic            rd_q;
  logic [NSS-1:0]  ss_q;
  logic            sclk_q;
  logic            mosi_q;
  logic            busy_q;
  logic            done_q;
  logic [D-1:0]    datao_q;

  logic [N-1:0]    frame_d;
  logic [D-1:0]    rx_d;
  logic            div_last_d;
  logic            bit_last_d;

  // Put an address field into transmit order (first bit sent ends up at the MSB).
  function automatic logic [A-1:0] order_addr(input logic [A-1:0] v);
    logic [A-1:0] r;
`ifdef SPI_REG_MASTER_LSB_FIRST_EN
    for (int i = 0; i < A; i++) begin
      r[i] = v[A-1-i];
    end
`else
    r = v;
`endif
    return r;
  endfunction

  // Put a data field into transmit order (first bit sent ends up at the MSB).
  function automatic logic [D-1:0] order_data(input logic [D-1:0] v);
    logic [D-1:0] r;
`ifdef SPI_REG_MASTER_LSB_FIRST_EN
    for (int i = 0; i < D; i++) begin
      r[i] = v[D-1-i];
    end
`else
    r = v;
`endif
    return r;
  endfunction

  // One-cold decode of the channel select; an out-of-range SEL selects nobody.
  function automatic logic [NSS-1:0] ss_decode(input logic [SW-1:0] sel);
    logic [NSS-1:0] r;
    r = {NSS{1'b1}};
    for (int i = 0; i < NSS; i++) begin
      if (sel == SW'(i)) begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Frame to load on acceptance; WR has priority, reads send zero data bits.
  always_comb begin
    if (WR) begin
      frame_d = {1'b1, order_addr(ADDR), order_data(DATAI)};
    end else begin
      frame_d = {1'b0, order_addr(ADDR), {D{1'b0}}};
    end
  end

  // Receive shifter: after N samples only the D data-field bits remain.
  always_comb begin
`ifdef SPI_REG_MASTER_LSB_FIRST_EN
    rx_d        = rx_q >> 1;
    rx_d[D-1]   = MISO;
`else
    rx_d        = rx_q << 1;
    rx_d[0]     = MISO;
`endif
  end

  // Phase-end and last-bit flags.
  always_comb begin
    div_last_d = (div_q == DW'(DIV - 1));
    bit_last_d = (bit_q == NW'(N - 1));
  end

  // Transfer FSM with all serial and handshake outputs registered.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      div_q   <= {DW{1'b0}};
      bit_q   <= {NW{1'b0}};
      tx_q    <= {N{1'b0}};
      rx_q    <= {D{1'b0}};
      rd_q    <= 1'b0;
      ss_q    <= {NSS{1'b1}};
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      datao_q <= {D{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (WR | RD) begin
            state_q <= S_SETUP;
            busy_q  <= 1'b1;
            ss_q    <= ss_decode(SEL);
            sclk_q  <= 1'b0;
            mosi_q  <= frame_d[N-1];
            tx_q    <= frame_d << 1;
            rd_q    <= ~WR;
            div_q   <= {DW{1'b0}};
            bit_q   <= {NW{1'b0}};
          end
        end
        S_SETUP: begin
          if (div_last_d) begin
            // First rising edge: the slave has had the whole setup to drive MISO.
            div_q   <= {DW{1'b0}};
            state_q <= S_SHIFT;
            sclk_q  <= 1'b1;
            rx_q    <= rx_d;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_SHIFT: begin
          if (div_last_d) begin
            div_q <= {DW{1'b0}};
            if (sclk_q) begin
              // Falling edge: present the next bit unless the frame is complete.
              sclk_q <= 1'b0;
              if (!bit_last_d) begin
                mosi_q <= tx_q[N-1];
                tx_q   <= tx_q << 1;
              end
            end else if (bit_last_d) begin
              state_q <= S_HOLD;
            end else begin
              bit_q  <= bit_q + NW'(1);
              sclk_q <= 1'b1;
              rx_q   <= rx_d;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_HOLD: begin
          if (div_last_d) begin
            div_q   <= {DW{1'b0}};
            bit_q   <= {NW{1'b0}};
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ss_q    <= {NSS{1'b1}};
            mosi_q  <= 1'b0;
            if (rd_q) begin
              datao_q <= rx_q;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          div_q   <= {DW{1'b0}};
          bit_q   <= {NW{1'b0}};
          ss_q    <= {NSS{1'b1}};
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DATAO = datao_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign SS    = ss_q;
  assign SCLK  = sclk_q;
  assign MOSI  = mosi_q;

endmodule

// File: doc/spi_reg_master.md
SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL provide parameters: D, default 8, data bits per frame; A, default 8, address bits per frame; DIV, default 2, CLOCK cycles per SCLK half-period (>=1); NSS, default 1, slave-select channels (1..8).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; SW = max(1, clog2(NSS)).
REQ-003 SHALL have ports: CLOCK  in  1  system clock; RESET  in  1  async active-high reset.
REQ-004 SHALL have ports: DATAI  in  D  write data; ADDR  in  A  register address; SEL  in  SW  slave channel; WR  in  1  write strobe; RD  in  1  read strobe.
REQ-005 SHALL have ports: DATAO  out  D  last read data; BUSY  out  1  transfer active; DONE  out  1  one-cycle completion pulse.
REQ-006 SHALL have ports: SS  out  NSS  active-low selects; SCLK  out  1  serial clock; MOSI  out  1  serial out; MISO  in  1  serial in.

Function
REQ-007 SHALL register all outputs; SCLK/MOSI/SS glitch-free, SPI mode 0 (SCLK idle low, MISO sampled on SCLK rise, MOSI changed on SCLK fall).
REQ-008 SHALL frame each transfer as N = 1+A+D bits: R/W bit (1=write, 0=read), then ADDR, then data.
REQ-009 SHALL accept a request on a CLOCK edge where (WR|RD)=1 and BUSY=0, latching DATAI, ADDR, SEL, WR; BUSY=1 from next cycle.
REQ-010 SHALL give WR priority when WR and RD are both high; strobes while BUSY=1 SHALL be ignored without effect.
REQ-011 SHALL implement states IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
REQ-012 SETUP: DIV cycles, SS[SEL]=0, SCLK=0, MOSI=first frame bit.
REQ-013 SHIFT: per bit, SCLK=1 for DIV cycles then SCLK=0 for DIV cycles; MISO sampled at SCLK rise; MOSI advances at SCLK fall (except after last bit).
REQ-014 HOLD: DIV cycles, SCLK=0, SS still asserted; then SS all ones, MOSI=0, state IDLE.
REQ-015 SHALL drive DONE=1 for exactly one cycle and BUSY=0 in that same cycle, DIV*(2N+2) cycles after acceptance; a new request is acceptable in the DONE cycle.
REQ-016 Read: SHALL drive MOSI=0 during data bits, shift D sampled MISO bits, update DATAO in the DONE cycle; write SHALL leave DATAO unchanged.
REQ-017 SEL >= NSS SHALL run full timing with no SS bit asserted; DONE still pulses.
REQ-018 Internal bit/divider counters SHALL be sized from N and DIV with no wrap before frame end.

Reset
REQ-019 RESET=1 SHALL immediately force: SS all ones, SCLK=0, MOSI=0, BUSY=0, DONE=0, DATAO=0, state IDLE, counters 0.
REQ-020 RESET mid-transfer SHALL abort the frame; no DONE pulse; first request after release starts a fresh frame.

Configuration
REQ-021 Macro SPI_REG_MASTER_LSB_FIRST_EN: defined -> ADDR and data fields (MOSI and MISO) shifted LSB first; undefined -> MSB first; R/W bit always first.

Verification
REQ-022 Write, A=D=8, DIV=2, ADDR=8'hA5, DATAI=8'h3C, macro off -> MOSI 1,10100101,00111100 on 17 rises; DONE 72 cycles after accept.
REQ-023 Read, ADDR=8'h0F, slave drives MISO=8'h96 MSB first -> MOSI 0,00001111,00000000; DATAO=8'h96 in DONE cycle.
REQ-024 NSS=4, SEL=2 -> only SS[2] low for the frame; SEL=3 with NSS=3 -> SS stays 3'b111, DONE pulses.
REQ-025 WR and RD together, then WR during BUSY -> single write frame; second strobe ignored; exactly one DONE.
REQ-026 RESET asserted mid-SHIFT -> outputs to reset values same cycle, no DONE; next write completes normally.
REQ-027 Macro on, write ADDR=8'hA5, DATAI=8'h3C -> MOSI 1,10100101,00111100 reversed per field: 1,10100101,00111100 -> 1,10100101,00111100 LSB-first = 1,10100101,00111100 with data bits 0,0,1,1,1,1,0,0.
